// File: rtl/sound_event_arbiter_if.sv
// Event, enable and audio-output bundle between the pong game logic and the sound arbiter.
// The master is the game side; the slave is the arbiter.
interface sound_event_arbiter_if;
  logic       enable;
  logic       evt_wall;
  logic       evt_paddle;
  logic       evt_score;
  logic       evt_over;
  logic       tone_out;
  logic       busy;
  logic [1:0] active_id;

  modport master (
    output enable, evt_wall, evt_paddle, evt_score, evt_over,
    input  tone_out, busy, active_id
  );

  modport slave (
    input  enable, evt_wall, evt_paddle, evt_score, evt_over,
    output tone_out, busy, active_id
  );
endinterface

// File: rtl/sound_event_arbiter.sv
// Fixed-priority arbiter for the four game-sound events. It plays one square-wave tone per grant
// and follows each tone with a silent gap.
module sound_event_arbiter #(
  parameter int unsigned HALF_WALL   = 31_468,
  parameter int unsigned HALF_PADDLE = 25_175,
  parameter int unsigned HALF_SCORE  = 50_350,
  parameter int unsigned HALF_OVER   = 62_937,
  parameter int unsigned DUR_SHORT   = 1_258_750,
  parameter int unsigned DUR_LONG    = 12_587_500,
  parameter int unsigned GAP_CYCLES  = 251_750,
  parameter int unsigned CNT_W       = 24
) (
  input  logic                 clk_0,
  input  logic                 rst,
  sound_event_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [CNT_W-1:0] HALF_WALL_M1   = CNT_W'(HALF_WALL - 1);
  localparam logic [CNT_W-1:0] HALF_PADDLE_M1 = CNT_W'(HALF_PADDLE - 1);
  localparam logic [CNT_W-1:0] HALF_SCORE_M1  = CNT_W'(HALF_SCORE - 1);
  localparam logic [CNT_W-1:0] HALF_OVER_M1   = CNT_W'(HALF_OVER - 1);
  localparam logic [CNT_W-1:0] DUR_SHORT_M1   = CNT_W'(DUR_SHORT - 1);
  localparam logic [CNT_W-1:0] DUR_LONG_M1    = CNT_W'(DUR_LONG - 1);
  localparam logic [CNT_W-1:0] GAP_M1         = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       pend_q, pend_d;
  logic [3:0]       evt_q, evt_d;
  logic [CNT_W-1:0] dur_q, dur_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic             tone_q, tone_d;
  logic             busy_q, busy_d;
  logic [1:0]       id_q, id_d;

  logic [3:0]       evt_c, rise_c, cand_vec_c;
  logic             cand_valid_c, grant_c;
  logic [1:0]       cand_id_c;
  logic [CNT_W-1:0] half_lim_c, dur_lim_c;

  // Bit index equals sound id: over(3) > score(2) > paddle(1) > wall(0)
  assign evt_c      = {bus.evt_over, bus.evt_score, bus.evt_paddle, bus.evt_wall};
  assign rise_c     = evt_c & ~evt_q;
  assign cand_vec_c = pend_q | rise_c;

  always_comb begin
    cand_valid_c = |cand_vec_c;
    cand_id_c    = 2'd0;
    if (cand_vec_c[3])      cand_id_c = 2'd3;
    else if (cand_vec_c[2]) cand_id_c = 2'd2;
    else if (cand_vec_c[1]) cand_id_c = 2'd1;
  end

  // Tone pitch and length of the sound currently playing
  always_comb begin
    half_lim_c = HALF_WALL_M1;
    dur_lim_c  = DUR_SHORT_M1;
    case (id_q)
      2'd1:    begin half_lim_c = HALF_PADDLE_M1; dur_lim_c = DUR_SHORT_M1; end
      2'd2:    begin half_lim_c = HALF_SCORE_M1;  dur_lim_c = DUR_LONG_M1;  end
      2'd3:    begin half_lim_c = HALF_OVER_M1;   dur_lim_c = DUR_LONG_M1;  end
      default: begin half_lim_c = HALF_WALL_M1;   dur_lim_c = DUR_SHORT_M1; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    pend_d  = cand_vec_c;
    evt_d   = evt_c;
    dur_d   = dur_q;
    half_d  = half_q;
    gap_d   = gap_q;
    tone_d  = tone_q;
    busy_d  = busy_q;
    id_d    = id_q;
    grant_c = 1'b0;

    if (!bus.enable) begin
      // Flush; evt_q keeps tracking so held levels do not retrigger later
      state_d = S_IDLE;
      pend_d  = 4'd0;
      dur_d   = '0;
      half_d  = '0;
      gap_d   = '0;
      tone_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: grant_c = cand_valid_c;
        S_PLAY: begin
          if (cand_valid_c && (cand_id_c > id_q)) begin
            grant_c = 1'b1;
          end else begin
            if (half_q == half_lim_c) begin
              half_d = '0;
              tone_d = ~tone_q;
            end else begin
              half_d = half_q + CNT_ONE;
            end
            if (dur_q == dur_lim_c) begin
              state_d = S_GAP;
              tone_d  = 1'b0;
              gap_d   = '0;
            end else begin
              dur_d = dur_q + CNT_ONE;
            end
          end
        end
        S_GAP: begin
          tone_d = 1'b0;
          if (gap_q == GAP_M1) begin
            if (cand_valid_c) begin
              grant_c = 1'b1;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            gap_d = gap_q + CNT_ONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (grant_c) begin
      state_d = S_PLAY;
      id_d    = cand_id_c;
      pend_d  = cand_vec_c & ~(4'b0001 << cand_id_c);
      dur_d   = '0;
      half_d  = '0;
      tone_d  = 1'b0;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_0) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pend_q  <= 4'd0;
      evt_q   <= 4'd0;
      dur_q   <= '0;
      half_q  <= '0;
      gap_q   <= '0;
      tone_q  <= 1'b0;
      busy_q  <= 1'b0;
      id_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      evt_q   <= evt_d;
      dur_q   <= dur_d;
      half_q  <= half_d;
      gap_q   <= gap_d;
      tone_q  <= tone_d;
      busy_q  <= busy_d;
      id_q    <= id_d;
    end
  end

  assign bus.tone_out  = tone_q;
  assign bus.busy      = busy_q;
  assign bus.active_id = id_q;

endmodule

// File: tb/tb_sound_event_arbiter.sv
// Self-checking bench for sound_event_arbiter: directed scenarios followed by random traffic.
// Every cycle is compared against a timeline-based reference model.
module tb_sound_event_arbiter;

  localparam int unsigned HW = 2, HP = 3, HS = 4, HO = 5;
  localparam int unsigned DS = 12, DL = 20, GP = 4;

  logic clk_0 = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  sound_event_arbiter_if bus ();

  sound_event_arbiter #(
    .HALF_WALL(HW), .HALF_PADDLE(HP), .HALF_SCORE(HS), .HALF_OVER(HO),
    .DUR_SHORT(DS), .DUR_LONG(DL), .GAP_CYCLES(GP), .CNT_W(24)
  ) dut (
    .clk_0(clk_0),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clk_0 = ~clk_0;

  // Model: phase 0 idle / 1 tone / 2 gap, m_t = cycles elapsed in the current phase
  int         m_phase, m_id, m_t;
  logic [3:0] m_pend, m_prev;

  function automatic int half_of(input int id);
    case (id)
      0: return HW;
      1: return HP;
      2: return HS;
      default: return HO;
    endcase
  endfunction

  function automatic int dur_of(input int id);
    return (id >= 2) ? DL : DS;
  endfunction

  task automatic grant(input int b);
    m_phase = 1;
    m_id    = b;
    m_pend[b] = 1'b0;
    m_t     = 0;
  endtask

  task automatic model_step();
    logic [3:0] ev, rise;
    int best;
    ev = {bus.evt_over, bus.evt_score, bus.evt_paddle, bus.evt_wall};
    if (!rst) begin
      m_phase = 0; m_id = 0; m_t = 0; m_pend = 4'd0; m_prev = 4'd0;
      return;
    end
    rise   = ev & ~m_prev;
    m_prev = ev;
    if (!bus.enable) begin
      m_phase = 0; m_pend = 4'd0; m_t = 0;
      return;
    end
    m_pend = m_pend | rise;
    best = -1;
    for (int i = 0; i < 4; i++) if (m_pend[i]) best = i;
    case (m_phase)
      0: if (best >= 0) grant(best);
      1: begin
        if (best > m_id) grant(best);
        else begin
          m_t++;
          if (m_t == dur_of(m_id)) begin m_phase = 2; m_t = 0; end
        end
      end
      default: begin
        m_t++;
        if (m_t == GP) begin
          if (best >= 0) grant(best);
          else m_phase = 0;
        end
      end
    endcase
  endtask

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle();
    logic exp_tone;
    @(posedge clk_0);
    model_step();
    #1;
    exp_tone = (m_phase == 1) ? 1'((m_t / half_of(m_id)) % 2) : 1'b0;
    check("tone_out",  {1'b0, bus.tone_out}, {1'b0, exp_tone});
    check("busy",      {1'b0, bus.busy},     {1'b0, 1'(m_phase != 0)});
    check("active_id", bus.active_id,        2'(m_id));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_ev(input logic [3:0] ev);
    bus.evt_wall   = ev[0];
    bus.evt_paddle = ev[1];
    bus.evt_score  = ev[2];
    bus.evt_over   = ev[3];
  endtask

  initial begin
    logic [3:0] rev;
    rst = 1'b0;
    bus.enable = 1'b1;
    set_ev(4'h0);

    // 1: reset with events toggling
    set_ev(4'hF); cycle();
    set_ev(4'h0); cycle();
    check("rst_busy", {1'b0, bus.busy}, 2'd0);
    check("rst_id", bus.active_id, 2'd0);
    rst = 1'b1;
    run(3);
    check("rst_noqueue", {1'b0, bus.busy}, 2'd0);

    // 2: single paddle pulse
    set_ev(4'b0010); cycle();
    check("t2_id", bus.active_id, 2'd1);
    check("t2_busy_k", {1'b0, bus.busy}, 2'd1);
    set_ev(4'h0); run(15);
    check("t2_busy_k15", {1'b0, bus.busy}, 2'd1);
    cycle();
    check("t2_busy_k16", {1'b0, bus.busy}, 2'd0);
    run(2);

    // 3: wall and score simultaneously
    set_ev(4'b0101); cycle();
    check("t3_first", bus.active_id, 2'd2);
    set_ev(4'h0); run(23);
    check("t3_still_score", bus.active_id, 2'd2);
    cycle();
    check("t3_wall_next", bus.active_id, 2'd0);
    check("t3_busy", {1'b0, bus.busy}, 2'd1);
    run(20);

    // 4: game over preempts a wall tone
    set_ev(4'b0001); cycle();
    set_ev(4'h0); run(4);
    set_ev(4'b1000); cycle();
    check("t4_preempt", bus.active_id, 2'd3);
    set_ev(4'h0); run(40);
    check("t4_no_replay", {1'b0, bus.busy}, 2'd0);

    // 5: game over held, two wall pulses during the tone
    for (int i = 0; i < 100; i++) begin
      set_ev({1'b1, 2'b00, 1'(i == 3 || i == 7)});
      cycle();
    end
    set_ev(4'h0); run(30);

    // 6: flush mid-tone with paddle pending, over rising while muted
    set_ev(4'b0100); cycle();
    set_ev(4'h0); run(3);
    set_ev(4'b0010); cycle();
    set_ev(4'h0); run(2);
    bus.enable = 1'b0;
    set_ev(4'b1000); cycle();
    check("t6_flush_busy", {1'b0, bus.busy}, 2'd0);
    check("t6_flush_tone", {1'b0, bus.tone_out}, 2'd0);
    run(3);
    bus.enable = 1'b1;
    run(10);
    check("t6_no_retrigger", {1'b0, bus.busy}, 2'd0);
    set_ev(4'h0); cycle();
    set_ev(4'b1000); cycle();
    check("t6_new_edge", bus.active_id, 2'd3);
    run(30);

    // Random traffic
    rev = 4'h0;
    for (int n = 0; n < 700; n++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) rev[b] = ~rev[b];
      set_ev(rev);
      bus.enable = ($urandom_range(0, 49) != 0);
      rst        = ($urandom_range(0, 299) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
